// File: rtl/keycode_event_queue_pkg.sv
// Shared types for the keycode event queue.
// Event record layout, event kinds and FSM states.
package keycode_event_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_REPEAT  = 2'd2
  } ev_kind_t;

  typedef struct packed {
    logic [7:0] code;
    ev_kind_t   kind;
  } ev_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REL   = 2'd1,
    S_PRESS = 2'd2
  } state_t;

endpackage

// File: rtl/keycode_event_queue_if.sv
// Event pop port of the keycode event queue.
// master = queue side, slave = consumer side.
interface keycode_event_queue_if #(
  parameter int DEPTH = 8
) ();

  logic                     ev_valid;
  logic                     ev_ready;
  logic [7:0]               ev_code;
  logic [1:0]               ev_kind;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     clear_overflow;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_kind,
    output count,
    output overflow,
    input  ev_ready,
    input  clear_overflow
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_kind,
    input  count,
    input  overflow,
    output ev_ready,
    output clear_overflow
  );

endinterface

// File: rtl/keycode_event_queue_sync_fifo.sv
// Generic first-word fall-through FIFO.
// A pop frees its slot in the same cycle, so push+pop when full is accepted.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rptr_q];

  // Next pointers, occupancy and storage write.
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (push_ok) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/keycode_event_queue.sv
// Turns the keycode PIO level into PRESS/RELEASE/REPEAT events.
// Input debounce, event FSM and typematic timer feed an event FIFO.
module keycode_event_queue #(
  parameter int DEPTH         = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_RATE   = 5_000_000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [7:0]           keycode_in,
  keycode_event_queue_if.master ev
);

  import keycode_event_pkg::*;

  localparam int SW   = $clog2(STABLE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int CW   = $clog2(DEPTH) + 1;

  logic [7:0]    samp_q, samp_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [7:0]    cur_q, cur_d;
  logic [7:0]    pend_q, pend_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          first_q, first_d;
  state_t        state_q, state_d;
  logic          overflow_q, overflow_d;

  logic          accept;
  logic          rpt_end;
  logic          push;
  ev_t           push_ev;
  ev_t           head;
  logic [9:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          drop;

  // Sample the PIO and count how long the sample has been steady.
  always_comb begin
    samp_d = keycode_in;
    stab_d = stab_q;
    if (samp_d != samp_q) begin
      stab_d = SW'(1);
    end else if (stab_q != SW'(STABLE_CYCLES)) begin
      stab_d = stab_q + 1'b1;
    end
  end

  assign accept  = (stab_q == SW'(STABLE_CYCLES)) &&
                   (samp_q != cur_q) &&
                   (state_q == S_IDLE);
  assign rpt_end = (rpt_q == (first_q ? RW'(REPEAT_DELAY - 1)
                                      : RW'(REPEAT_RATE - 1)));

  // Event FSM and repeat timer; at most one enqueue per cycle.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    rpt_d   = rpt_q;
    first_d = first_q;
    push    = 1'b0;
    push_ev = '{code: KEY_NONE, kind: EV_PRESS};
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          pend_d = samp_q;
          if (cur_q != KEY_NONE) begin
            state_d = S_REL;
          end else begin
            state_d = S_PRESS;
          end
        end else if (cur_q != KEY_NONE) begin
          if (rpt_end) begin
            push    = 1'b1;
            push_ev = '{code: cur_q, kind: EV_REPEAT};
            rpt_d   = '0;
            first_d = 1'b0;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end else begin
          rpt_d = '0;
        end
      end
      S_REL: begin
        push    = 1'b1;
        push_ev = '{code: cur_q, kind: EV_RELEASE};
        cur_d   = KEY_NONE;
        rpt_d   = '0;
        state_d = (pend_q != KEY_NONE) ? S_PRESS : S_IDLE;
      end
      S_PRESS: begin
        push    = 1'b1;
        push_ev = '{code: pend_q, kind: EV_PRESS};
        cur_d   = pend_q;
        rpt_d   = '0;
        first_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A full FIFO drops the event unless the consumer pops this cycle.
  assign drop = push && fifo_full && !(ev.ev_ready && !fifo_empty);

  // Sticky overflow; a drop beats a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ev.clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Sampler, FSM and flag registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      samp_q     <= KEY_NONE;
      stab_q     <= '0;
      cur_q      <= KEY_NONE;
      pend_q     <= KEY_NONE;
      rpt_q      <= '0;
      first_q    <= 1'b0;
      state_q    <= S_IDLE;
      overflow_q <= 1'b0;
    end else begin
      samp_q     <= samp_d;
      stab_q     <= stab_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      rpt_q      <= rpt_d;
      first_q    <= first_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (10),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (push),
    .din   (push_ev),
    .pop   (ev.ev_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head        = ev_t'(fifo_dout);
  assign ev.ev_valid = !fifo_empty;
  assign ev.ev_code  = fifo_empty ? KEY_NONE : head.code;
  assign ev.ev_kind  = fifo_empty ? 2'd0 : head.kind;
  assign ev.count    = fifo_count;
  assign ev.overflow = overflow_q;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue.
// Small delays so repeat timing is visible in a short run.
module tb_keycode_event_queue;

  import keycode_event_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode_in;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;

  int rc_code[$];
  int rc_kind[$];
  int rc_cyc[$];

  keycode_event_queue_if #(.DEPTH(4)) ev_if ();

  keycode_event_queue #(
    .DEPTH         (4),
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (20),
    .REPEAT_RATE   (8)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode_in (keycode_in),
    .ev         (ev_if)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    Reset                = 1'b1;
    keycode_in           = 8'h00;
    ev_if.ev_ready       = 1'b0;
    ev_if.clear_overflow = 1'b0;
    step();
    step();
    Reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic record_to(input int n);
    while (cyc < n) begin
      if (ev_if.ev_valid) begin
        rc_code.push_back(int'(ev_if.ev_code));
        rc_kind.push_back(int'(ev_if.ev_kind));
        rc_cyc.push_back(cyc);
      end
      step();
    end
  endtask

  initial begin
    int e_kind[6] = '{0, 2, 2, 2, 2, 1};
    int e_cyc[6]  = '{6, 26, 34, 42, 50, 56};

    // 1: reset state, PRESS latency
    do_reset();
    check("rst_valid", ev_if.ev_valid, 0);
    check("rst_count", ev_if.count, 0);
    check("rst_ovf", ev_if.overflow, 0);
    check("rst_code", ev_if.ev_code, 0);
    check("rst_kind", ev_if.ev_kind, 0);
    keycode_in = 8'h1A;
    to_cyc(5);
    check("t1_valid_c5", ev_if.ev_valid, 0);
    to_cyc(6);
    check("t1_valid_c6", ev_if.ev_valid, 1);
    check("t1_code", ev_if.ev_code, 8'h1A);
    check("t1_kind", ev_if.ev_kind, EV_PRESS);
    check("t1_count", ev_if.count, 1);
    to_cyc(20);
    check("t1_no_more", ev_if.count, 1);

    // 2: PRESS, typematic REPEATs, RELEASE
    do_reset();
    ev_if.ev_ready = 1'b1;
    keycode_in     = 8'h04;
    record_to(50);
    keycode_in = 8'h00;
    record_to(80);
    check("t2_n_events", rc_code.size(), 6);
    if (rc_code.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("t2_code%0d", i), rc_code[i], 8'h04);
        check($sformatf("t2_kind%0d", i), rc_kind[i], e_kind[i]);
        check($sformatf("t2_cyc%0d", i), rc_cyc[i], e_cyc[i]);
      end
    end

    // 3: direct code-to-code change
    do_reset();
    keycode_in = 8'h1A;
    to_cyc(10);
    keycode_in = 8'h07;
    to_cyc(15);
    check("t3_count_c15", ev_if.count, 1);
    to_cyc(16);
    check("t3_count_c16", ev_if.count, 2);
    to_cyc(17);
    check("t3_count_c17", ev_if.count, 3);
    to_cyc(20);
    ev_if.ev_ready = 1'b1;
    check("t3_h0_code", ev_if.ev_code, 8'h1A);
    check("t3_h0_kind", ev_if.ev_kind, EV_PRESS);
    step();
    check("t3_h1_code", ev_if.ev_code, 8'h1A);
    check("t3_h1_kind", ev_if.ev_kind, EV_RELEASE);
    step();
    check("t3_h2_code", ev_if.ev_code, 8'h07);
    check("t3_h2_kind", ev_if.ev_kind, EV_PRESS);
    step();
    check("t3_empty", ev_if.count, 0);

    // 4: short glitch is filtered
    do_reset();
    keycode_in = 8'h16;
    to_cyc(2);
    keycode_in = 8'h00;
    to_cyc(17);
    check("t4_count", ev_if.count, 0);
    check("t4_valid", ev_if.ev_valid, 0);

    // 5: overflow, pop+push when full, clear
    do_reset();
    keycode_in = 8'h1A;
    to_cyc(10);
    keycode_in = 8'h07;
    to_cyc(20);
    keycode_in = 8'h00;
    to_cyc(30);
    keycode_in = 8'h04;
    to_cyc(35);
    check("t5_ovf_c35", ev_if.overflow, 0);
    to_cyc(40);
    check("t5_count", ev_if.count, 4);
    check("t5_ovf", ev_if.overflow, 1);
    check("t5_h0_code", ev_if.ev_code, 8'h1A);
    check("t5_h0_kind", ev_if.ev_kind, EV_PRESS);
    to_cyc(55);
    ev_if.ev_ready = 1'b1;
    step();
    ev_if.ev_ready = 1'b0;
    check("t5_full_pp", ev_if.count, 4);
    check("t5_ovf_kept", ev_if.overflow, 1);
    ev_if.clear_overflow = 1'b1;
    step();
    ev_if.clear_overflow = 1'b0;
    check("t5_ovf_clr", ev_if.overflow, 0);
    ev_if.ev_ready = 1'b1;
    check("t5_h1_code", ev_if.ev_code, 8'h1A);
    check("t5_h1_kind", ev_if.ev_kind, EV_RELEASE);
    step();
    check("t5_h2_code", ev_if.ev_code, 8'h07);
    check("t5_h2_kind", ev_if.ev_kind, EV_PRESS);
    step();
    check("t5_h3_code", ev_if.ev_code, 8'h07);
    check("t5_h3_kind", ev_if.ev_kind, EV_RELEASE);
    step();
    check("t5_h4_code", ev_if.ev_code, 8'h04);
    check("t5_h4_kind", ev_if.ev_kind, EV_REPEAT);
    step();
    check("t5_drained", ev_if.count, 0);

    // 6: reset mid-operation, then fresh PRESS only
    do_reset();
    keycode_in = 8'h04;
    to_cyc(35);
    check("t6_count_pre", ev_if.count, 3);
    to_cyc(36);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("t6_valid", ev_if.ev_valid, 0);
    check("t6_count", ev_if.count, 0);
    check("t6_ovf", ev_if.overflow, 0);
    ev_if.ev_ready = 1'b1;
    rc_code.delete();
    rc_kind.delete();
    rc_cyc.delete();
    record_to(60);
    check("t6_n_events", rc_code.size(), 1);
    if (rc_code.size() >= 1) begin
      check("t6_code", rc_code[0], 8'h04);
      check("t6_kind", rc_kind[0], EV_PRESS);
      check("t6_cyc", rc_cyc[0], 43);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
